// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
//   Phase sequencer for the single-issue multicycle CPU. It steps each
//   instruction through FETCH -> DECODE -> [MEM] -> WB, generates one-hot Moore
//   phase strobes, and owns the program counter. It also handles relative
//   branches, halt, and run/idle control.
//
//   Optional feature: define MULTICYCLE_SEQ_PERF_EN to build the retired and
//   stall performance counters. When it is undefined, both counter ports
//   read 0.
//
// Ports
//   clk            : clock, rising edge
//   reset          : synchronous, active-high reset
//   run            : level; allows a new instruction to start
//   is_mem_op      : from decode, sampled in DECODE
//   mem_ready      : data memory done, sampled in MEM
//   branch_taken   : sampled in WB
//   branch_offset  : signed offset in instructions, sampled in WB
//   halt_insn      : sampled in WB; takes priority over the branch
//   pc             : address of the current instruction
//   fetch_en/decode_en/mem_en/wb_en : one-hot phase strobes
//   mem_req        : data memory request (same as mem_en)
//   halted         : high in HALT
//   retired_count  : instructions retired (saturating)
//   stall_count    : MEM cycles with mem_ready low (saturating)
// -----------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter int PC_W     = 32,
    parameter int PC_STEP  = 4,
    parameter int RESET_PC = 0,
    parameter int OFF_W    = 24,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             is_mem_op,
    input  logic             mem_ready,
    input  logic             branch_taken,
    input  logic [OFF_W-1:0] branch_offset,
    input  logic             halt_insn,
    output logic [PC_W-1:0]  pc,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             mem_req,
    output logic             halted,
    output logic [CNT_W-1:0] retired_count,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // PC_STEP is a power of two, so offset * PC_STEP is a left shift.
    localparam int STEP_SH = $clog2(PC_STEP);
    // The offset is sign-extended to at least PC_W bits before it is
    // truncated, so a wide offset simply wraps modulo 2^PC_W.
    localparam int EXT_W   = (OFF_W > PC_W) ? OFF_W : PC_W;

    state_t state, state_nxt;

    logic [EXT_W-1:0] off_wide;
    logic [PC_W-1:0]  off_bytes;
    logic [PC_W-1:0]  pc_seq;
    logic [PC_W-1:0]  pc_nxt;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (run) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = is_mem_op ? S_MEM : S_WB;
            S_MEM:    if (mem_ready) state_nxt = S_WB;
            S_WB: begin
                if (halt_insn) state_nxt = S_HALT;
                else if (run)  state_nxt = S_FETCH;
                else           state_nxt = S_IDLE;
            end
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // ---------------- Moore outputs ----------------
    always_comb begin
        fetch_en  = 1'b0;
        decode_en = 1'b0;
        mem_en    = 1'b0;
        wb_en     = 1'b0;
        halted    = 1'b0;
        case (state)
            S_FETCH:  fetch_en  = 1'b1;
            S_DECODE: decode_en = 1'b1;
            S_MEM:    mem_en    = 1'b1;
            S_WB:     wb_en     = 1'b1;
            S_HALT:   halted    = 1'b1;
            default:  ;
        endcase
    end

    assign mem_req = mem_en;

    // ---------------- program counter ----------------
    assign off_wide  = EXT_W'($signed(branch_offset));
    assign off_bytes = off_wide[PC_W-1:0] << STEP_SH;
    assign pc_seq    = pc + PC_W'(PC_STEP);
    assign pc_nxt    = branch_taken ? (pc_seq + off_bytes) : pc_seq;

    // A halting WB leaves the PC on the halt instruction.
    always_ff @(posedge clk) begin
        if (reset)                          pc <= PC_W'(RESET_PC);
        else if (state == S_WB && !halt_insn) pc <= pc_nxt;
    end

    // ---------------- performance counters ----------------
`ifdef MULTICYCLE_SEQ_PERF_EN
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (state == S_WB && !(&retired_q))
                retired_q <= retired_q + 1'b1;
            if (state == S_MEM && !mem_ready && !(&stall_q))
                stall_q <= stall_q + 1'b1;
        end
    end

    assign retired_count = retired_q;
    assign stall_count   = stall_q;
`else
    assign retired_count = '0;
    assign stall_count   = '0;
`endif

endmodule
